// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined unsigned multiply-add / running-accumulate unit.
// Build option: define MAC_PIPE_SATURATE_EN to clamp DATA_OUT on accumulate overflow (default wraps).
module mac_pipe #(
  parameter int P     = 8,        // operand width, same default as the SystemVerilog1Param package
  parameter int ACC_W = 2*P + 4,  // must be >= 2*P
  parameter int CNT_W = 8
) (
  input  logic             C,
  input  logic             RST,
  input  logic             IN_VALID,
  input  logic             MODE,
  input  logic             START,
  input  logic [P-1:0]     A1,
  input  logic [P-1:0]     B1,
  input  logic [P-1:0]     C1,
  output logic             OUT_VALID,
  output logic [ACC_W-1:0] DATA_OUT,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);

  // Stage 1: product and side-band registers.
  logic           s1_valid;
  logic [2*P-1:0] s1_prod;
  logic [P-1:0]   s1_add;
  logic           s1_mode;
  logic           s1_start;

  // NOTE: the data registers are reset as well as the valid bit; it costs little
  // here and keeps X out of the adder if the valid logic is ever changed.
  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_add   <= '0;
      s1_mode  <= 1'b0;
      s1_start <= 1'b0;
    end else begin
      s1_valid <= IN_VALID;
      if (IN_VALID) begin
        s1_prod  <= (2*P)'(A1) * (2*P)'(B1);
        s1_add   <= C1;
        s1_mode  <= MODE;
        s1_start <= START;
      end
    end
  end

  // Stage 2 next-state: restart (multiply-add or START) or accumulate onto DATA_OUT.
  logic             restart;
  logic [ACC_W:0]   acc_sum;
  logic             carry;
  logic [ACC_W-1:0] data_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_nxt;

  // NOTE: combinational blocks use blocking '=' with every output defaulted first
  // (no latches); the clocked blocks use only non-blocking '<='.
  always_comb begin
    restart   = !s1_mode || s1_start;
    acc_sum   = {1'b0, DATA_OUT} + (ACC_W+1)'(s1_prod);
    carry     = acc_sum[ACC_W];
    data_nxt  = DATA_OUT;
    count_nxt = COUNT;
    ovf_nxt   = OVF;
    if (restart) begin
      data_nxt  = ACC_W'(s1_prod) + ACC_W'(s1_add);
      count_nxt = CNT_W'(1);
      ovf_nxt   = 1'b0;
    end else begin
      ovf_nxt   = OVF | carry;
`ifdef MAC_PIPE_SATURATE_EN
      // Once overflowed, the accumulation stays pinned at full scale until restart.
      data_nxt  = (OVF || carry) ? '1 : acc_sum[ACC_W-1:0];
`else
      data_nxt  = acc_sum[ACC_W-1:0];
`endif
      count_nxt = (COUNT == '1) ? COUNT : COUNT + CNT_W'(1);
    end
  end

  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      DATA_OUT  <= '0;
      COUNT     <= '0;
      OVF       <= 1'b0;
    end else begin
      OUT_VALID <= s1_valid;
      if (s1_valid) begin
        DATA_OUT <= data_nxt;
        COUNT    <= count_nxt;
        OVF      <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: randomized and directed checks of mac_pipe against a queue-based result model.
// Build option: define MAC_PIPE_SATURATE_EN for both RTL and bench to check the clamping build.
module tb_mac_pipe;
  localparam int     P       = 8;
  localparam int     ACC_W   = 20;
  localparam int     CNT_W   = 8;
  localparam longint ACC_MOD = 64'd1 << ACC_W;
  localparam int     CNT_MAX = (1 << CNT_W) - 1;

  logic             C = 1'b0;
  logic             RST = 1'b1;
  logic             IN_VALID = 1'b0;
  logic             MODE = 1'b0;
  logic             START = 1'b0;
  logic [P-1:0]     A1 = '0;
  logic [P-1:0]     B1 = '0;
  logic [P-1:0]     C1 = '0;
  logic             OUT_VALID;
  logic [ACC_W-1:0] DATA_OUT;
  logic [CNT_W-1:0] COUNT;
  logic             OVF;

  mac_pipe #(.P(P), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .C(C), .RST(RST), .IN_VALID(IN_VALID), .MODE(MODE), .START(START),
    .A1(A1), .B1(B1), .C1(C1),
    .OUT_VALID(OUT_VALID), .DATA_OUT(DATA_OUT), .COUNT(COUNT), .OVF(OVF)
  );

  always #5 C = ~C;

  // Reference model: each accepted input is turned into its final result at once
  // and queued until the cycle the DUT should present it.
  typedef struct {
    int     due;
    longint data;
    int     count;
    bit     ovf;
  } result_t;

  result_t pend[$];
  longint  m_acc;
  int      m_cnt;
  bit      m_ovf;
  bit      exp_valid;
  longint  exp_data;
  int      exp_cnt;
  bit      exp_ovf;
  int      edge_n;
  int      n_checks = 0;
  int      n_fail = 0;

  task automatic model_reset();
    pend.delete();
    m_acc = 0; m_cnt = 0; m_ovf = 0;
    exp_valid = 0; exp_data = 0; exp_cnt = 0; exp_ovf = 0;
    edge_n = 0;
  endtask

  // Apply one cycle of inputs, advance past the edge, update the expectations.
  task automatic step(input bit v, input bit m, input bit s, input int a, input int b, input int c);
    result_t r;
    IN_VALID = v; MODE = m; START = s;
    A1 = P'(a); B1 = P'(b); C1 = P'(c);
    @(posedge C);
    edge_n++;
    if (!RST) begin
      exp_valid = 0;
      if (pend.size() != 0 && pend[0].due == edge_n) begin
        r = pend.pop_front();
        exp_valid = 1; exp_data = r.data; exp_cnt = r.count; exp_ovf = r.ovf;
      end
      if (v) begin
        if (!m || s) begin
          m_acc = longint'(a) * b + c;
          m_cnt = 1;
          m_ovf = 0;
        end else begin
          m_acc = m_acc + longint'(a) * b;
          if (m_acc >= ACC_MOD) m_ovf = 1;
`ifdef MAC_PIPE_SATURATE_EN
          if (m_ovf) m_acc = ACC_MOD - 1;
`else
          m_acc = m_acc % ACC_MOD;
`endif
          if (m_cnt < CNT_MAX) m_cnt++;
        end
        r.due = edge_n + 1; r.data = m_acc; r.count = m_cnt; r.ovf = m_ovf;
        pend.push_back(r);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", OUT_VALID); end
    n_checks++; if (DATA_OUT !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", DATA_OUT); end
    n_checks++; if (COUNT !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", OVF); end
    @(posedge C); #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_mult_add();
    step(1, 0, 0, 255, 255, 255);
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL madd_valid: got %b want 1", OUT_VALID); end
    n_checks++; if (DATA_OUT !== 20'd65280) begin n_fail++; $display("FAIL madd_data: got %0d want 65280", DATA_OUT); end
    n_checks++; if (COUNT !== 8'd1) begin n_fail++; $display("FAIL madd_count: got %0d want 1", COUNT); end
    n_checks++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL madd_ovf: got %b want 0", OVF); end
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL madd_single_pulse: got %b want 0", OUT_VALID); end
    n_checks++; if (DATA_OUT !== 20'd65280) begin n_fail++; $display("FAIL madd_hold: got %0d want 65280", DATA_OUT); end
    // START with MODE=0 is a plain multiply-add; then an un-started accumulate continues it.
    step(1, 0, 1, 3, 4, 5);
    step(1, 1, 0, 2, 2, 77);
    n_checks++; if (DATA_OUT !== 20'd17 || COUNT !== 8'd1) begin n_fail++; $display("FAIL madd_start_ignored: got %0d/%0d want 17/1", DATA_OUT, COUNT); end
    step(0, 0, 0, 0, 0, 0);
    n_checks++; if (DATA_OUT !== 20'd21 || COUNT !== 8'd2) begin n_fail++; $display("FAIL madd_continue: got %0d/%0d want 21/2", DATA_OUT, COUNT); end
    n_checks++; if (DATA_OUT !== exp_data[ACC_W-1:0]) begin n_fail++; $display("FAIL madd_model: got %0d want %0d", DATA_OUT, exp_data); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_accumulate();
    for (int k = 0; k < 6; k++) begin
      if (k == 0)     step(1, 1, 1, 10, 20, 5);
      else if (k < 4) step(1, 1, 0, 10, 20, 99);
      else            step(0, 0, 0, 0, 0, 0);
      if (k >= 1 && k <= 4) begin
        n_checks++;
        if (OUT_VALID !== 1'b1 || DATA_OUT !== ACC_W'(5 + 200 * k) || COUNT !== CNT_W'(k)) begin
          n_fail++;
          $display("FAIL acc_out%0d: got v=%b d=%0d c=%0d want v=1 d=%0d c=%0d", k, OUT_VALID, DATA_OUT, COUNT, 5 + 200 * k, k);
        end
      end else begin
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL acc_idle%0d: got %b want 0", k, OUT_VALID); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 20; k++) begin
      if (k == 0)       step(1, 1, 1, 255, 255, 0);
      else if (k < 17)  step(1, 1, 0, 255, 255, 0);
      else if (k == 17) step(1, 1, 1, 2, 3, 1);
      else              step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (OUT_VALID !== exp_valid || DATA_OUT !== exp_data[ACC_W-1:0] || COUNT !== CNT_W'(exp_cnt) || OVF !== exp_ovf) begin
        n_fail++;
        $display("FAIL ovf_model%0d: got v=%b d=%0d c=%0d o=%b want v=%b d=%0d c=%0d o=%b",
                 k, OUT_VALID, DATA_OUT, COUNT, OVF, exp_valid, exp_data, exp_cnt, exp_ovf);
      end
      if (k == 16) begin
        n_checks++; if (DATA_OUT !== 20'd1040400 || OVF !== 1'b0) begin n_fail++; $display("FAIL ovf_out16: got %0d/%b want 1040400/0", DATA_OUT, OVF); end
      end
      if (k == 17) begin
`ifdef MAC_PIPE_SATURATE_EN
        n_checks++; if (DATA_OUT !== 20'd1048575) begin n_fail++; $display("FAIL ovf_out17_sat: got %0d want 1048575", DATA_OUT); end
`else
        n_checks++; if (DATA_OUT !== 20'd56849) begin n_fail++; $display("FAIL ovf_out17_wrap: got %0d want 56849", DATA_OUT); end
`endif
        n_checks++; if (OVF !== 1'b1 || COUNT !== 8'd17) begin n_fail++; $display("FAIL ovf_flag17: got %b/%0d want 1/17", OVF, COUNT); end
      end
      if (k == 18) begin
        n_checks++; if (OVF !== 1'b0 || DATA_OUT !== 20'd7) begin n_fail++; $display("FAIL ovf_clear: got %b/%0d want 0/7", OVF, DATA_OUT); end
      end
    end
  endtask

  task automatic test_bubbles();
    bit want;
    for (int i = 0; i < 8; i++) begin
      step((i == 0 || i == 3 || i == 4), 0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      want = (i == 1 || i == 4 || i == 5);
      n_checks++;
      if (OUT_VALID !== want || DATA_OUT !== exp_data[ACC_W-1:0]) begin
        n_fail++;
        $display("FAIL bubble_cycle%0d: got v=%b d=%0d want v=%b d=%0d", i + 1, OUT_VALID, DATA_OUT, want, exp_data);
      end
    end
  endtask

  task automatic test_count_sat();
    step(1, 1, 1, 0, 0, 9);
    for (int i = 0; i < 262; i++) begin
      step(i < 260, 1, 0, 0, 0, 0);
      n_checks++;
      if (COUNT !== CNT_W'(exp_cnt) || OUT_VALID !== exp_valid) begin
        n_fail++;
        $display("FAIL cnt_model%0d: got c=%0d v=%b want c=%0d v=%b", i, COUNT, OUT_VALID, exp_cnt, exp_valid);
      end
    end
    n_checks++;
    if (COUNT !== 8'd255 || DATA_OUT !== 20'd9 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_saturate: got c=%0d d=%0d o=%b want c=255 d=9 o=0", COUNT, DATA_OUT, OVF);
    end
  endtask

  task automatic test_random();
    bit v, m, s;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0);
      step(v, m, s, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      n_checks++;
      if (OUT_VALID !== exp_valid || DATA_OUT !== exp_data[ACC_W-1:0] || COUNT !== CNT_W'(exp_cnt) || OVF !== exp_ovf) begin
        n_fail++;
        $display("FAIL rand%0d: got v=%b d=%0d c=%0d o=%b want v=%b d=%0d c=%0d o=%b",
                 i, OUT_VALID, DATA_OUT, COUNT, OVF, exp_valid, exp_data, exp_cnt, exp_ovf);
      end
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    step(1, 1, 1, 1, 2, 3);
    step(1, 1, 0, 4, 5, 0);
    // Term 2 now sits in stage 1; term 3 is presented while reset hits.
    IN_VALID = 1'b1; MODE = 1'b1; START = 1'b0; A1 = 8'd6; B1 = 8'd7; C1 = 8'd0;
    RST = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (OUT_VALID !== 1'b0 || DATA_OUT !== '0 || COUNT !== '0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b d=%0d c=%0d o=%b want all 0", OUT_VALID, DATA_OUT, COUNT, OVF);
    end
    @(posedge C); #1;
    IN_VALID = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (OUT_VALID !== 1'b0 || DATA_OUT !== '0) begin
        n_fail++;
        $display("FAIL midrst_quiet%0d: got v=%b d=%0d want v=0 d=0", i, OUT_VALID, DATA_OUT);
      end
    end
    step(1, 1, 1, 2, 3, 1);
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (OUT_VALID !== 1'b1 || DATA_OUT !== 20'd7 || COUNT !== 8'd1 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_restart: got v=%b d=%0d c=%0d o=%b want v=1 d=7 c=1 o=0", OUT_VALID, DATA_OUT, COUNT, OVF);
    end
  endtask

  initial begin
    test_reset();
    test_mult_add();
    test_accumulate();
    test_overflow();
    test_bubbles();
    test_count_sat();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
